// File: rtl/quad_operand_serial_adder.sv
// -----------------------------------------------------------------------------
// quad_operand_serial_adder
//
// Bit-serial sum of four WIDTH-bit unsigned operands. A single four-input full
// adder column is evaluated once per cycle, LSB first, over WIDTH+2 bit slots.
// The column produces three outputs:
//   b_out  (weight 1) -> shifted into the result register MSB
//   c0_out (weight 2) -> fed back as c0_in on the next slot
//   c1_out (weight 4) -> fed back as c1_in two slots later (via c1_a, c1_b)
// The last two slots carry zero data bits and only flush the carries. The
// largest possible sum, 4*(2^WIDTH-1), fits in WIDTH+2 bits, so every carry
// has drained to zero by the time the result is presented.
//
// Ports:
//   clk_in         clock, rising edge
//   rst_n_in       asynchronous active-low reset
//   op_valid_in    operand set valid
//   op_ready_out   block can accept an operand set (high in IDLE only)
//   a0_in..a3_in   WIDTH-bit operands
//   res_valid_out  sum_out holds a completed result (high in DONE)
//   res_ready_in   consumer accepts the result
//   sum_out        WIDTH+2-bit sum a0+a1+a2+a3
//   busy_out       high while an operation is in RUN or DONE
// -----------------------------------------------------------------------------
module quad_operand_serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             op_valid_in,
   output logic             op_ready_out,
   input  logic [WIDTH-1:0] a0_in,
   input  logic [WIDTH-1:0] a1_in,
   input  logic [WIDTH-1:0] a2_in,
   input  logic [WIDTH-1:0] a3_in,
   output logic             res_valid_out,
   input  logic             res_ready_in,
   output logic [WIDTH+1:0] sum_out,
   output logic             busy_out
);

   localparam int unsigned RES_W = WIDTH + 2;
   localparam int unsigned CNT_W = $clog2(WIDTH + 2);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e             state_q;

   // Operand shift registers; zero fill makes the flush slots feed zero bits.
   logic [WIDTH-1:0]   a0_q;
   logic [WIDTH-1:0]   a1_q;
   logic [WIDTH-1:0]   a2_q;
   logic [WIDTH-1:0]   a3_q;

   logic [RES_W-1:0]   res_q;
   logic [CNT_W-1:0]   cnt_q;

   // Carry feedback: c0 returns after one slot, c1 after two (c1_a -> c1_b).
   logic               c0_q;
   logic               c1_a;
   logic               c1_b;

   // Registered handshake/status outputs.
   logic               op_ready_q;
   logic               res_valid_q;
   logic               busy_q;

   // Four-input full adder column.
   logic [2:0]         col_sum;
   logic               b_out;
   logic               c0_out;
   logic               c1_out;

   always_comb begin
      col_sum = 3'(a0_q[0]) + 3'(a1_q[0]) + 3'(a2_q[0]) + 3'(a3_q[0])
              + 3'(c0_q) + 3'(c1_b);
      b_out   = col_sum[0];
      c0_out  = col_sum[1];
      c1_out  = col_sum[2];
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= StIdle;
         a0_q        <= '0;
         a1_q        <= '0;
         a2_q        <= '0;
         a3_q        <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         c0_q        <= 1'b0;
         c1_a        <= 1'b0;
         c1_b        <= 1'b0;
         op_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (op_valid_in && op_ready_q) begin
                  a0_q        <= a0_in;
                  a1_q        <= a1_in;
                  a2_q        <= a2_in;
                  a3_q        <= a3_in;
                  cnt_q       <= '0;
                  c0_q        <= 1'b0;
                  c1_a        <= 1'b0;
                  c1_b        <= 1'b0;
                  state_q     <= StRun;
                  op_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end

            StRun: begin
               a0_q  <= a0_q >> 1;
               a1_q  <= a1_q >> 1;
               a2_q  <= a2_q >> 1;
               a3_q  <= a3_q >> 1;
               res_q <= {b_out, res_q[RES_W-1:1]};
               c0_q  <= c0_out;
               c1_b  <= c1_a;
               c1_a  <= c1_out;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_SLOT) begin
                  state_q     <= StDone;
                  res_valid_q <= 1'b1;
               end
            end

            StDone: begin
               // Result register is untouched here, so sum_out is stable
               // for however long the consumer stalls.
               if (res_ready_in) begin
                  state_q     <= StIdle;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  op_ready_q  <= 1'b1;
               end
            end

            default: begin
               state_q     <= StIdle;
               res_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               op_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign op_ready_out  = op_ready_q;
   assign res_valid_out = res_valid_q;
   assign busy_out      = busy_q;
   assign sum_out       = res_q;

endmodule

// File: tb/tb_quad_operand_serial_adder.sv
module tb_quad_operand_serial_adder;

   localparam int unsigned W = 8;

   logic           clk_in;
   logic           rst_n_in;
   logic           op_valid_in;
   logic           op_ready_out;
   logic [W-1:0]   a0_in;
   logic [W-1:0]   a1_in;
   logic [W-1:0]   a2_in;
   logic [W-1:0]   a3_in;
   logic           res_valid_out;
   logic           res_ready_in;
   logic [W+1:0]   sum_out;
   logic           busy_out;

   quad_operand_serial_adder #(.WIDTH(W)) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .op_valid_in   (op_valid_in),
      .op_ready_out  (op_ready_out),
      .a0_in         (a0_in),
      .a1_in         (a1_in),
      .a2_in         (a2_in),
      .a3_in         (a3_in),
      .res_valid_out (res_valid_out),
      .res_ready_in  (res_ready_in),
      .sum_out       (sum_out),
      .busy_out      (busy_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned edge_cnt = 0;
   int unsigned n_results = 0;
   int unsigned last_acc = 0;
   int unsigned prev_acc = 0;
   int unsigned exp_q[$];
   logic        prev_valid = 1'b0;
   logic [31:0] held_sum = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   initial forever begin
      @(posedge clk_in);
      edge_cnt++;
   end

   // Reference model: each accepted operand set is summed with plain integer
   // arithmetic and queued; results must come out in order.
   initial forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
         exp_q.delete();
         prev_valid = 1'b0;
      end else begin
         if (op_valid_in && op_ready_out) begin
            exp_q.push_back(int'(a0_in) + int'(a1_in) + int'(a2_in) + int'(a3_in));
            prev_acc = last_acc;
            last_acc = edge_cnt + 1;
         end
         if (res_valid_out && !prev_valid) begin
            check("latency", 32'(edge_cnt - last_acc), W + 2);
            check("carry_zero", {29'd0, dut.c0_q, dut.c1_a, dut.c1_b}, 32'd0);
            held_sum = 32'(sum_out);
         end else if (res_valid_out) begin
            check("sum_hold", 32'(sum_out), held_sum);
         end
         if (res_valid_out && res_ready_in) begin
            if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
            else check("sum", 32'(sum_out), exp_q.pop_front());
            n_results++;
         end
         prev_valid = res_valid_out;
      end
   end

   task automatic sync();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_in);
         if (op_ready_out) begin
            ok = 1'b1;
            break;
         end
      end
      sync();
      op_valid_in = 1'b0;
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [W-1:0] x0, input logic [W-1:0] x1,
                       input logic [W-1:0] x2, input logic [W-1:0] x3,
                       input int unsigned stall);
      op_valid_in = 1'b0;
      repeat (stall) sync();
      a0_in = x0;
      a1_in = x1;
      a2_in = x2;
      a3_in = x3;
      op_valid_in = 1'b1;
      wait_accept();
   endtask

   task automatic wait_results(input int unsigned target);
      int unsigned cyc = 0;
      while (n_results < target && cyc < 400) begin
         @(negedge clk_in);
         cyc++;
      end
      if (n_results < target) check("result_timeout", 32'(n_results), 32'(target));
   endtask

   bit rand_done;

   initial begin
      int unsigned base;
      rst_n_in     = 1'b1;
      op_valid_in  = 1'b0;
      res_ready_in = 1'b1;
      a0_in = '0;
      a1_in = '0;
      a2_in = '0;
      a3_in = '0;
      #1 rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check("rst_op_ready", 32'(op_ready_out), 32'd1);
      check("rst_res_valid", 32'(res_valid_out), 32'd0);
      check("rst_sum", 32'(sum_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd0);
      @(posedge clk_in);
      #2 rst_n_in = 1'b1;
      sync();

      // All-zero operands, then all-ones (longest carry chain).
      send(8'h00, 8'h00, 8'h00, 8'h00, 0);
      wait_results(1);
      send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
      wait_results(2);
      @(negedge clk_in);
      check("idle_ready", 32'(op_ready_out), 32'd1);
      check("idle_busy", 32'(busy_out), 32'd0);
      check("idle_sum_hold", 32'(sum_out), 32'h3FC);

      // Back-to-back with the consumer always ready.
      sync();
      send(8'h01, 8'h02, 8'h03, 8'h04, 0);
      send(8'hAA, 8'h55, 8'hF0, 8'h0F, 0);
      check("b2b_gap", 32'(last_acc - prev_acc), 32'd12);
      wait_results(4);

      // Long backpressure with a new operand set waiting.
      sync();
      res_ready_in = 1'b0;
      send(8'h10, 8'h20, 8'h30, 8'h40, 0);
      for (int i = 0; i < 40 && !res_valid_out; i++) @(negedge clk_in);
      sync();
      a0_in = 8'h77;
      a1_in = 8'h77;
      a2_in = 8'h77;
      a3_in = 8'h77;
      op_valid_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         check("bp_valid", 32'(res_valid_out), 32'd1);
         check("bp_ready", 32'(op_ready_out), 32'd0);
         check("bp_busy", 32'(busy_out), 32'd1);
         check("bp_sum", 32'(sum_out), 32'h0A0);
      end
      sync();
      res_ready_in = 1'b1;
      wait_accept();
      wait_results(6);

      // Asynchronous reset mid-run, counter at 4.
      sync();
      send(8'h11, 8'h22, 8'h33, 8'h44, 0);
      repeat (4) @(posedge clk_in);
      #3 rst_n_in = 1'b0;
      #1;
      check("midrst_op_ready", 32'(op_ready_out), 32'd1);
      check("midrst_res_valid", 32'(res_valid_out), 32'd0);
      check("midrst_sum", 32'(sum_out), 32'd0);
      check("midrst_busy", 32'(busy_out), 32'd0);
      @(posedge clk_in);
      #2 rst_n_in = 1'b1;
      base = n_results;
      repeat (12) sync();
      check("midrst_no_result", 32'(n_results), 32'(base));
      send(8'h01, 8'h01, 8'h01, 8'h01, 0);
      wait_results(base + 1);

      // Randomized operands with random valid and ready stalls.
      base = n_results;
      rand_done = 1'b0;
      sync();
      fork
         begin
            for (int i = 0; i < 500; i++)
               send(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    $urandom_range(0, 3));
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               sync();
               res_ready_in = ($urandom_range(0, 3) != 0);
            end
         end
      join
      res_ready_in = 1'b1;
      wait_results(base + 500);
      repeat (2) @(negedge clk_in);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/quad_operand_serial_adder.md
Name: quad_operand_serial_adder

Overview:
- Bit-serial controller that sums four WIDTH-bit unsigned operands.
- Sequences a single four_input_full_adder cell LSB-first, one bit per cycle.
- Manages the two carry feedback paths: c0 has weight 2 and returns one cycle later; c1 has weight 4 and returns two cycles later.
- Operands arrive over a valid/ready handshake and the WIDTH+2-bit sum leaves over a second valid/ready handshake. The block is the area-minimal multi-operand reduction stage of the datapath.

Parameters:
- WIDTH, 8, operand width in bits (>=2). Result width is WIDTH+2. Counter width is $clog2(WIDTH+2).

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  reset; asynchronous, active-low.
- op_valid_in  input  1  operand set valid.
- op_ready_out  output  1  block can accept an operand set.
- a0_in  input  WIDTH  operand 0.
- a1_in  input  WIDTH  operand 1.
- a2_in  input  WIDTH  operand 2.
- a3_in  input  WIDTH  operand 3.
- res_valid_out  output  1  sum_out holds a completed result.
- res_ready_in  input  1  consumer accepts the result.
- sum_out  output  WIDTH+2  a0+a1+a2+a3, unsigned.
- busy_out  output  1  high in RUN and DONE.

Behaviour:
- Reset (rst_n_in low, any state including mid-RUN):
  - state=IDLE; operand shift registers, result register, bit counter and carry registers c0_q, c1_a, c1_b all cleared to 0.
  - Outputs: op_ready_out=1, res_valid_out=0, sum_out=0, busy_out=0.
  - An in-flight operation is discarded and produces no result.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - op_ready_out=1.
  - On op_valid_in & op_ready_out at an edge: load a0..a3 into four shift registers, clear c0_q/c1_a/c1_b and the counter, go to RUN.
  - op_valid_in while not IDLE is ignored; the source must hold it.
- RUN (op_ready_out=0, busy_out=1), each cycle:
  - Compressor inputs: the LSB of each operand register; c0_in=c0_q; c1_in=c1_b.
  - At the edge:
    - Operand registers shift right with zero fill.
    - Result register shifts right, with b_out entering bit WIDTH+1.
    - Carries update: c0_q<=c0_out, c1_b<=c1_a, c1_a<=c1_out.
    - Counter increments.
  - When the counter equals WIDTH+1 (the last of WIDTH+2 bit slots), go to DONE at that edge.
  - Carry-flush cycles WIDTH and WIDTH+1 feed zero data bits.
- DONE:
  - res_valid_out=1, busy_out=1.
  - sum_out is held stable until res_valid_out & res_ready_in at an edge; then go to IDLE.
  - Backpressure of any length holds the result.
- Latency and throughput:
  - res_valid_out rises exactly WIDTH+2 edges after the accepting edge.
  - If res_ready_in=1 when the result appears, the next operand set can be accepted WIDTH+4 edges after the previous accept. No overlap of operations.
- Arithmetic: sum_out = a0+a1+a2+a3 exactly; the maximum 4*(2^WIDTH-1) always fits in WIDTH+2 bits, so there is no overflow.
- Invariant: c0_q, c1_a and c1_b are all 0 on entry to DONE. The bench checks this with an assertion.
- sum_out outside DONE: it shows the result register. During RUN it shifts and is don't-care. In IDLE it holds the last delivered result (0 after reset).
- Ready/valid handshakes are the only flow control. No combinational path exists from op_valid_in to op_ready_out or from res_ready_in to res_valid_out.

Test Plan:
- WIDTH=8, operands 0x00,0x00,0x00,0x00 accepted at edge 0 -> res_valid_out high after edge 10, sum_out=0x000; final carries 0.
- Operands 0xFF,0xFF,0xFF,0xFF -> sum_out=0x3FC. Exercises the maximum-weight carry chain and both flush cycles.
- Operands 0x01,0x02,0x03,0x04, then 0xAA,0x55,0xF0,0x0F back-to-back with res_ready_in=1 -> sum_out 0x00A, then 0x1FE; second accept occurs exactly 12 edges after the first.
- Hold res_ready_in=0 for 20 cycles in DONE with op_valid_in=1 -> res_valid_out=1 and sum_out constant, op_ready_out=0, no operand captured. Release -> IDLE, then accept.
- Assert rst_n_in low asynchronously (between edges) when the counter is 4 mid-RUN -> outputs go to reset values immediately, with no res_valid_out. Then operands 0x01 x4 -> sum_out=0x004 after 10 edges.
- 500 random operand sets with random valid/ready stalls -> every sum_out matches the reference model sum, and the carry-zero assertion never fires.
